uart_word_tx: RTL and testbench
===============================

Name: uart_word_tx

Overview:
Serial transmitter, the outbound counterpart of the UART loader receiver. Accepts one 32-bit address/data pair through a valid/ready handshake and sends it on the tx pin as 8N1 bytes, framed for the loader's receiver. Used for memory/register readback and debug dumps from the CPU or MMIO side to the host PC. Runs on the same UART clock domain (upg_clk) as the receiver.

Parameters:
CLKS_PER_BIT, 87, clock cycles per serial bit; the default gives 115200 baud at 10 MHz; must be >= 2.
SEND_ADDR, 1, 1 = send the 4 address bytes before the 4 data bytes; 0 = send the data bytes only.

Ports:
clk  input  1  UART clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request to send in_addr/in_data
in_ready  output  1  high when idle and able to accept a word
in_addr  input  32  address word, sampled on accept
in_data  input  32  data word, sampled on accept
tx  output  1  serial line, idles high
busy  output  1  high from the cycle after accept until the last stop bit ends
done  output  1  one-cycle pulse when the word is fully sent

Behaviour:
- Reset (asynchronous, active-high): tx=1, in_ready=1, busy=0, done=0, all counters 0, FSM in IDLE. Reset mid-frame forces tx high immediately; the partial frame is abandoned with no done pulse.
- Accept: in_valid && in_ready at a rising edge latches in_addr/in_data into a 64-bit shift register. On the next cycle in_ready=0 and busy=1. in_valid while busy is ignored, and no value is queued.
- Byte order: addr[7:0], addr[15:8], addr[23:16], addr[31:24], data[7:0] ... data[31:24]. With SEND_ADDR=0, only the 4 data bytes are sent, in that order. N_BYTES = 8 or 4.
- Byte frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles, so one byte is 10*CLKS_PER_BIT cycles.
- Timing: the first start bit drives tx low on the cycle after accept. Bytes go back-to-back with no idle gap; the next start bit immediately follows the previous stop bit.
- Total latency: from the accept edge to the end of the last stop bit is N_BYTES*10*CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: wait for accept, then go to START.
  - START: after CLKS_PER_BIT cycles, go to DATA.
  - DATA: after 8 bits, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, go to START if bytes remain, otherwise go to IDLE.
- Done/ready: on the STOP-to-IDLE transition, done=1 for exactly one cycle. In that same cycle in_ready=1 and busy=0.
- Back-to-back words: a new word may be accepted in the same cycle done is high. Its start bit then follows on the next cycle, so there is no idle bit between words.
- Counters: the baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit counter is 3 bits. The byte counter is 3 bits and wraps at N_BYTES-1. No counter may overflow within a frame.
- Output register: tx is registered to avoid glitches. It is constant for each full bit period.

Decomposition:
- Shared package uart_pkg holds:
  - the default CLKS_PER_BIT value;
  - the FSM state encoding (IDLE, START, DATA, STOP);
  - the BYTES_PER_WORD=4 constant, which the receiver also uses.
- One sub-module is natural: uart_byte_tx. It is an 8N1 single-byte serializer with start/busy/done and the baud counter. uart_word_tx sequences bytes into it and owns the handshake.

Test Plan:
- Single word, CLKS_PER_BIT=4, SEND_ADDR=1, addr=0x00000010, data=0xDEADBEEF:
  - The line decodes bytes 10 00 00 00 EF BE AD DE.
  - done pulses exactly 320 cycles after accept.
  - tx=1 before and after.
- SEND_ADDR=0, data=0x12345678: the line shows bytes 78 56 34 12. done at 160 cycles. in_ready=0 throughout busy.
- in_valid held high for two words, 0xA5A5A5A5 then 0x0000FFFF:
  - The second word is accepted in the done cycle.
  - No idle bit appears between the stop bit and the next start bit.
  - 16 bytes are decoded correctly.
- Pulse in_valid with data=0xFFFFFFFF while busy sending 0x00000000: it is ignored, only the first word appears on the line, and in_ready stays 0.
- Assert reset during the 3rd data bit of byte 2:
  - tx=1 asynchronously; busy=0, in_ready=1; no done pulse.
  - A subsequent word 0xCAFEF00D is sent correctly from its start bit.
- Bit timing check with CLKS_PER_BIT=87: every tx level holds for exactly 87 cycles, measured at all 80 bit boundaries of one word.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and serializer FSM encoding
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 87;
  localparam int BYTES_PER_WORD       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  function automatic int word_bytes(input bit send_addr);
    return send_addr ? 2 * BYTES_PER_WORD : BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// rtl/uart_word_tx_if.sv - address/data word handshake into the UART word transmitter
interface uart_word_tx_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;

  modport master (output in_valid, output in_addr, output in_data, input in_ready);
  modport slave  (input in_valid, input in_addr, input in_data, output in_ready);

endinterface

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 single-byte serializer with baud counter
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_n;
  logic [BW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    sh, sh_n;
  logic          tx_n;
  logic          tick;

  assign tick = (baud_cnt == BAUD_LAST);
  assign busy = (state != ST_IDLE);
  // done marks the final cycle of the stop bit so a follow-on start is seamless
  assign done = (state == ST_STOP) && tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      sh       <= sh_n;
      tx       <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    sh_n       = sh;
    tx_n       = tx;
    if (state != ST_IDLE) begin
      baud_cnt_n = tick ? '0 : baud_cnt + 1'b1;
    end
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n    = ST_START;
          sh_n       = data;
          tx_n       = 1'b0;
          baud_cnt_n = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_n   = ST_DATA;
          bit_cnt_n = 3'd0;
          tx_n      = sh[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt == 3'd7) begin
            state_n = ST_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            sh_n      = {1'b0, sh[7:1]};
            tx_n      = sh[1];
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (start) begin
            state_n = ST_START;
            sh_n    = data;
            tx_n    = 1'b0;
          end else begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - sends one address/data word as back-to-back 8N1 bytes
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter bit SEND_ADDR    = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  uart_word_tx_if.slave   word,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int         N_BYTES   = word_bytes(SEND_ADDR);
  localparam logic [2:0] LAST_BYTE = 3'(N_BYTES - 1);

  logic [63:0] word_sh;
  logic [63:0] load_word;
  logic [2:0]  byte_cnt;
  logic [7:0]  byte_data;
  logic        byte_busy, byte_done, byte_start;
  logic        ready, accept, last_byte, word_done;

  assign last_byte = (byte_cnt == LAST_BYTE);
  assign word_done = byte_done && last_byte;
  // a new word may be taken in the last stop-bit cycle of the previous one
  assign ready     = !byte_busy || word_done;
  assign accept    = word.in_valid && ready;
  assign busy      = byte_busy && !word_done;
  assign done      = word_done;
  assign word.in_ready = ready;

  assign load_word  = SEND_ADDR ? {word.in_data, word.in_addr} : {32'd0, word.in_data};
  assign byte_start = accept || (byte_done && !last_byte);
  assign byte_data  = accept ? load_word[7:0] : word_sh[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_sh  <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      word_sh  <= load_word >> 8;
      byte_cnt <= 3'd0;
    end else if (byte_done) begin
      word_sh  <= word_sh >> 8;
      byte_cnt <= last_byte ? 3'd0 : byte_cnt + 3'd1;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk   (clk),
    .reset (reset),
    .start (byte_start),
    .data  (byte_data),
    .tx    (tx),
    .busy  (byte_busy),
    .done  (byte_done)
  );

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - directed bench for uart_word_tx
module tb_uart_word_tx;

  logic        clk;
  logic        reset;
  logic        drv_valid;
  logic [31:0] drv_addr;
  logic [31:0] drv_data;
  int          sel;
  int          n_checks;
  int          n_fail;

  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;
  logic tx_c, busy_c, done_c;
  logic obs_tx, obs_ready, obs_busy, obs_done;

  logic       tx_tr    [0:8191];
  logic       done_tr  [0:8191];
  logic       ready_tr [0:8191];
  logic       busy_tr  [0:8191];
  logic [7:0] exp_b    [0:15];

  uart_word_tx_if ifa ();
  uart_word_tx_if ifb ();
  uart_word_tx_if ifc ();

  assign ifa.in_valid = drv_valid && (sel == 0);
  assign ifb.in_valid = drv_valid && (sel == 1);
  assign ifc.in_valid = drv_valid && (sel == 2);
  assign ifa.in_addr  = drv_addr;
  assign ifb.in_addr  = drv_addr;
  assign ifc.in_addr  = drv_addr;
  assign ifa.in_data  = drv_data;
  assign ifb.in_data  = drv_data;
  assign ifc.in_data  = drv_data;

  uart_word_tx #(.CLKS_PER_BIT(4), .SEND_ADDR(1'b1)) dut_a (
    .clk(clk), .reset(reset), .word(ifa), .tx(tx_a), .busy(busy_a), .done(done_a));
  uart_word_tx #(.CLKS_PER_BIT(4), .SEND_ADDR(1'b0)) dut_b (
    .clk(clk), .reset(reset), .word(ifb), .tx(tx_b), .busy(busy_b), .done(done_b));
  uart_word_tx #(.CLKS_PER_BIT(87), .SEND_ADDR(1'b1)) dut_c (
    .clk(clk), .reset(reset), .word(ifc), .tx(tx_c), .busy(busy_c), .done(done_c));

  assign obs_tx    = (sel == 0) ? tx_a : (sel == 1) ? tx_b : tx_c;
  assign obs_ready = (sel == 0) ? ifa.in_ready : (sel == 1) ? ifb.in_ready : ifc.in_ready;
  assign obs_busy  = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  assign obs_done  = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_exp(input int off, input logic [31:0] addr, input logic [31:0] data,
                         input bit send_addr);
    for (int i = 0; i < 4; i++) begin
      if (send_addr) begin
        exp_b[off + i]     = addr[8*i +: 8];
        exp_b[off + 4 + i] = data[8*i +: 8];
      end else begin
        exp_b[off + i]     = data[8*i +: 8];
      end
    end
  endtask

  task automatic start_word(input logic [31:0] addr, input logic [31:0] data, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    while (!obs_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("pre_ready", obs_ready, 1);
    check_eq("pre_tx_idle", obs_tx, 1);
    drv_addr  = addr;
    drv_data  = data;
    drv_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) drv_valid = 1'b0;
  endtask

  // cycle 1 is the cycle right after the accept edge
  task automatic capture(input int total, input int hold_until, input int pulse_at);
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      tx_tr[c]    = obs_tx;
      done_tr[c]  = obs_done;
      ready_tr[c] = obs_ready;
      busy_tr[c]  = obs_busy;
      if (c == hold_until) drv_valid = 1'b0;
      if (pulse_at > 0 && c == pulse_at) begin
        drv_valid = 1'b1;
        drv_data  = 32'hFFFF_FFFF;
      end
      if (pulse_at > 0 && c == pulse_at + 1) drv_valid = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input int nb, input int cpb);
    int   wrong, good_bits;
    logic e, ok;
    logic [7:0] val;
    wrong = 0;
    good_bits = 0;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < 10; j++) begin
        e  = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_b[i][j-1];
        ok = 1'b1;
        for (int k = 0; k < cpb; k++) begin
          if (tx_tr[1 + (i*10 + j)*cpb + k] !== e) begin
            ok = 1'b0;
            wrong++;
          end
        end
        if (ok) good_bits++;
      end
      val = 8'h00;
      for (int j = 1; j <= 8; j++) val[j-1] = tx_tr[1 + (i*10 + j)*cpb + cpb/2];
      check_eq($sformatf("%s_byte%0d", tag, i), val, exp_b[i]);
    end
    check_eq({tag, "_wave_err_cycles"}, wrong, 0);
    check_eq({tag, "_exact_bits"}, good_bits, nb*10);
  endtask

  task automatic check_handshake(input string tag, input int total, input int wlen);
    int   err, first, ndone;
    logic e;
    err = 0;
    first = 0;
    ndone = 0;
    for (int c = 1; c <= total; c++) begin
      e = ((c % wlen) == 0);
      if (done_tr[c] !== e) err++;
      if (ready_tr[c] !== e) err++;
      if (busy_tr[c] !== !e) err++;
      if (done_tr[c] === 1'b1) begin
        ndone++;
        if (first == 0) first = c;
      end
    end
    check_eq({tag, "_hs_err"}, err, 0);
    check_eq({tag, "_done_lat"}, first, wlen);
    check_eq({tag, "_done_cnt"}, ndone, total / wlen);
  endtask

  task automatic idle_tail(input string tag, input int cycles);
    int err;
    err = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_ready !== 1'b1) err++;
    end
    check_eq({tag, "_idle_tail_err"}, err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int err;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    drv_valid = 1'b0;
    drv_addr  = '0;
    drv_data  = '0;
    sel       = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hold_tx", tx_a, 1);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_tx", tx_a, 1);
    check_eq("rst_ready", ifa.in_ready, 1);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_c_tx", tx_c, 1);

    sel = 0;
    start_word(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    capture(320, 0, 0);
    set_exp(0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    check_frame("single", 8, 4);
    check_handshake("single", 320, 320);
    idle_tail("single", 8);

    sel = 1;
    start_word(32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    capture(160, 0, 0);
    set_exp(0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    check_frame("data_only", 4, 4);
    check_handshake("data_only", 160, 160);
    idle_tail("data_only", 8);

    sel = 0;
    start_word(32'h0000_0100, 32'hA5A5_A5A5, 1'b1);
    drv_addr = 32'h0000_0104;
    drv_data = 32'h0000_FFFF;
    capture(640, 640, 0);
    set_exp(0, 32'h0000_0100, 32'hA5A5_A5A5, 1'b1);
    set_exp(8, 32'h0000_0104, 32'h0000_FFFF, 1'b1);
    check_frame("b2b", 16, 4);
    check_handshake("b2b", 640, 320);
    idle_tail("b2b", 8);

    sel = 1;
    start_word(32'h0, 32'h0000_0000, 1'b0);
    capture(160, 0, 50);
    set_exp(0, 32'h0, 32'h0000_0000, 1'b0);
    check_frame("ignored", 4, 4);
    check_handshake("ignored", 160, 160);
    idle_tail("ignored", 12);

    sel = 0;
    start_word(32'h0000_0010, 32'h1122_3344, 1'b0);
    for (int c = 1; c <= 54; c++) @(negedge clk);
    check_eq("mid_pre_tx", tx_a, 0);
    check_eq("mid_pre_busy", busy_a, 1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_tx", tx_a, 1);
    check_eq("mid_rst_busy", busy_a, 0);
    check_eq("mid_rst_ready", ifa.in_ready, 1);
    check_eq("mid_rst_done", done_a, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    err = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) err++;
    end
    check_eq("mid_rst_quiet", err, 0);
    start_word(32'h0000_0000, 32'hCAFE_F00D, 1'b0);
    capture(320, 0, 0);
    set_exp(0, 32'h0000_0000, 32'hCAFE_F00D, 1'b1);
    check_frame("after_rst", 8, 4);
    check_handshake("after_rst", 320, 320);

    sel = 2;
    start_word(32'h3C5A_0F81, 32'h96C3_E71E, 1'b0);
    capture(6960, 0, 0);
    set_exp(0, 32'h3C5A_0F81, 32'h96C3_E71E, 1'b1);
    check_frame("baud87", 8, 87);
    check_handshake("baud87", 6960, 6960);
    idle_tail("baud87", 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
